// File: rtl/ir_pkg.sv
// Shared event encodings, FSM states and event field layout for the IR key-event block.
package ir_pkg;

  localparam int EV_CMD_W    = 8;
  localparam int EV_ADDR_W   = 8;
  localparam int EV_TYPE_W   = 2;
  localparam int EV_CMD_LSB  = 0;
  localparam int EV_ADDR_LSB = EV_CMD_LSB + EV_CMD_W;
  localparam int EV_TYPE_LSB = EV_ADDR_LSB + EV_ADDR_W;
  localparam int EV_W        = EV_TYPE_LSB + EV_TYPE_W;
  localparam int KEY_W       = EV_ADDR_W + EV_CMD_W;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_REPEAT  = 2'b10,
    EV_RELEASE = 2'b11
  } ev_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    SWAP = 2'd2
  } state_e;

  function automatic logic [EV_W-1:0] mk_event(ev_type_e t, logic [KEY_W-1:0] key);
    return {t, key};
  endfunction

endpackage

// File: rtl/ir_event_fifo.sv
// First-word-fall-through event FIFO; head is forced to zero while empty.
module ir_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot this cycle, so a push while full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ir_key_event.sv
// NEC frame -> PRESS/REPEAT/RELEASE key events, buffered in a FWFT FIFO.
// Optional build macro IR_ADDR_FILTER_EN restricts accepted frames to DEV_ADDR.
module ir_key_event
  import ir_pkg::*;
#(
  parameter int         RELEASE_DUR = 6000000,
  parameter int         REPEAT_SKIP = 3,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] DEV_ADDR    = 8'h00
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iDATA,
  input  logic        iDATA_READY,
  output logic [17:0] oEVENT,
  output logic        oEVENT_VALID,
  input  logic        iEVENT_READY,
  output logic        oHELD,
  output logic [7:0]  oDROP_CNT
);

  state_e           state_q;
  logic [31:0]      timer_q;
  logic [KEY_W-1:0] key_q;
  logic [7:0]       skip_q;
  logic [7:0]       drop_q;
  logic             held_q;

  logic             addr_ok, accept, same_key, expire;
  logic [KEY_W-1:0] key_in;
  logic             push, pop, full, empty;
  logic [EV_W-1:0]  push_data;
  logic             unused_ok;

`ifdef IR_ADDR_FILTER_EN
  assign addr_ok = (iDATA[7:0] == DEV_ADDR);
`else
  assign addr_ok = 1'b1;
`endif
  assign unused_ok = ^{iDATA[15:8], DEV_ADDR};

  assign accept   = iDATA_READY && (iDATA[31:24] == ~iDATA[23:16]) && addr_ok;
  assign key_in   = {iDATA[7:0], iDATA[23:16]};
  assign same_key = (key_in == key_q);
  assign expire   = (timer_q == 32'd1);
  assign pop      = !empty && iEVENT_READY;

  always_comb begin
    push      = 1'b0;
    push_data = mk_event(EV_RELEASE, key_q);
    case (state_q)
      IDLE: if (accept) begin
        push      = 1'b1;
        push_data = mk_event(EV_PRESS, key_in);
      end
      HELD: begin
        if (accept) begin
          if (!same_key) begin
            push = 1'b1;
          end else if (skip_q == 8'(REPEAT_SKIP)) begin
            push      = 1'b1;
            push_data = mk_event(EV_REPEAT, key_q);
          end
        end else if (expire) begin
          push = 1'b1;
        end
      end
      SWAP: begin
        push      = 1'b1;
        push_data = mk_event(EV_PRESS, key_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      timer_q <= '0;
      key_q   <= '0;
      skip_q  <= '0;
      drop_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      if (push && full && !pop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: if (accept) begin
          key_q   <= key_in;
          timer_q <= 32'(RELEASE_DUR);
          skip_q  <= '0;
          held_q  <= 1'b1;
          state_q <= HELD;
        end
        HELD: begin
          // A frame landing on the expiry cycle keeps the key held.
          if (accept) begin
            timer_q <= 32'(RELEASE_DUR);
            if (!same_key) begin
              key_q   <= key_in;
              skip_q  <= '0;
              state_q <= SWAP;
            end else if (skip_q == 8'(REPEAT_SKIP)) begin
              skip_q <= '0;
            end else begin
              skip_q <= skip_q + 8'd1;
            end
          end else if (expire) begin
            timer_q <= '0;
            held_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        SWAP: state_q <= HELD;
        default: begin
          held_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  ir_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (oEVENT),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign oEVENT_VALID = !empty;
  assign oHELD        = held_q;
  assign oDROP_CNT    = drop_q;

endmodule

// File: tb/tb_ir_key_event.sv
// Directed bench for ir_key_event (short RELEASE_DUR so timeouts are cheap).
module tb_ir_key_event;

  localparam int RD = 40;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iDATA;
  logic        iDATA_READY;
  logic [17:0] oEVENT;
  logic        oEVENT_VALID;
  logic        iEVENT_READY;
  logic        oHELD;
  logic [7:0]  oDROP_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  ir_key_event #(.RELEASE_DUR(RD), .REPEAT_SKIP(3), .FIFO_DEPTH(4), .DEV_ADDR(8'h00)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iDATA        (iDATA),
    .iDATA_READY  (iDATA_READY),
    .oEVENT       (oEVENT),
    .oEVENT_VALID (oEVENT_VALID),
    .iEVENT_READY (iEVENT_READY),
    .oHELD        (oHELD),
    .oDROP_CNT    (oDROP_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    iDATA       = d;
    iDATA_READY = 1'b1;
    step();
    iDATA_READY = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [17:0] exp);
    chk({tag, "_valid"}, 32'(oEVENT_VALID), 32'd1);
    chk(tag, 32'(oEVENT), 32'(exp));
    iEVENT_READY = 1'b1;
    step();
    iEVENT_READY = 1'b0;
  endtask

  initial begin
    iRST = 1'b1; iDATA = '0; iDATA_READY = 1'b0; iEVENT_READY = 1'b0;
    step(); step();
    chk("rst_valid", 32'(oEVENT_VALID), 32'd0);
    chk("rst_event", 32'(oEVENT), 32'd0);
    chk("rst_held",  32'(oHELD), 32'd0);
    chk("rst_drop",  32'(oDROP_CNT), 32'd0);
    iRST = 1'b0;
    step();

    // Single press, exact release timing
    send(32'hF708_FF00);
    chk("press_held", 32'(oHELD), 32'd1);
    pop_chk("press_ev", 18'h1_0008);
    repeat (RD - 2) step();
    chk("pre_rel_valid", 32'(oEVENT_VALID), 32'd0);
    chk("pre_rel_held",  32'(oHELD), 32'd1);
    step();
    chk("rel_held", 32'(oHELD), 32'd0);
    pop_chk("rel_ev", 18'h3_0008);
    chk("rel_empty", 32'(oEVENT_VALID), 32'd0);

    // Held key: 8 repeats with REPEAT_SKIP=3 -> two REPEATs
    send(32'hF708_FF00);
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      send(32'hF708_FF00);
    end
    repeat (RD + 5) step();
    chk("rep_drop", 32'(oDROP_CNT), 32'd0);
    pop_chk("rep_press", 18'h1_0008);
    pop_chk("rep_r1",    18'h2_0008);
    pop_chk("rep_r2",    18'h2_0008);
    pop_chk("rep_rel",   18'h3_0008);
    chk("rep_empty", 32'(oEVENT_VALID), 32'd0);

    // Key change before timeout, then a bad-complement frame
    send(32'hF708_FF00);
    repeat (4) step();
    send(32'hE31C_FF00);
    repeat (2) step();
    pop_chk("swap_p08", 18'h1_0008);
    pop_chk("swap_r08", 18'h3_0008);
    pop_chk("swap_p1c", 18'h1_001C);
    chk("swap_held", 32'(oHELD), 32'd1);
    send(32'h0008_FF00);
    step();
    chk("bad_valid", 32'(oEVENT_VALID), 32'd0);
    chk("bad_held",  32'(oHELD), 32'd1);
    repeat (RD + 5) step();
    pop_chk("swap_r1c", 18'h3_001C);
    chk("swap_idle", 32'(oHELD), 32'd0);

    // Overflow: 6 events into a 4-deep FIFO
    send(32'hF708_FF00);
    repeat (4) step();
    send(32'hE31C_FF00);
    repeat (4) step();
    send(32'hF708_FF00);
    repeat (RD + 5) step();
    chk("ovf_drop", 32'(oDROP_CNT), 32'd2);
    chk("ovf_held", 32'(oHELD), 32'd0);
    iEVENT_READY = 1'b1;
    chk("ovf_e0", 32'(oEVENT), 32'h1_0008); step();
    chk("ovf_e1", 32'(oEVENT), 32'h3_0008); step();
    chk("ovf_e2", 32'(oEVENT), 32'h1_001C);
    chk("ovf_v2", 32'(oEVENT_VALID), 32'd1); step();
    chk("ovf_e3", 32'(oEVENT), 32'h3_001C);
    chk("ovf_v3", 32'(oEVENT_VALID), 32'd1); step();
    chk("ovf_empty", 32'(oEVENT_VALID), 32'd0);
    iEVENT_READY = 1'b0;

    // Address filter, then reset with queued events
`ifdef IR_ADDR_FILTER_EN
    send(32'hF708_FF01);
    chk("filt_valid", 32'(oEVENT_VALID), 32'd0);
    chk("filt_held",  32'(oHELD), 32'd0);
    send(32'hF708_FF00);
    chk("filt_press", 32'(oEVENT), 32'h1_0008);
    repeat (4) step();
    send(32'hE31C_FF00);
`else
    send(32'hF708_FF01);
    chk("nofilt_press", 32'(oEVENT), 32'h1_0108);
    chk("nofilt_held",  32'(oHELD), 32'd1);
    repeat (4) step();
    send(32'hE31C_FF01);
`endif
    step();
    chk("prerst_valid", 32'(oEVENT_VALID), 32'd1);
    chk("prerst_drop",  32'(oDROP_CNT), 32'd2);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    chk("mrst_valid", 32'(oEVENT_VALID), 32'd0);
    chk("mrst_drop",  32'(oDROP_CNT), 32'd0);
    chk("mrst_held",  32'(oHELD), 32'd0);
    chk("mrst_event", 32'(oEVENT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
